// File: rtl/time_adjust_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// time_adjust_ctrl_pkg
// Shared definitions for the front-panel time adjust controller:
//   - FSM state encoding (ST_RUN, ST_ADJUST)
//   - field index encoding shared with time_float and the display
//     (SEL_MS_LO = 0 .. SEL_YEAR_3 = 15)
//   - key slot indices for the debouncer bank
//   - next_field(): select advance with wrap from last back to first
// -----------------------------------------------------------------------------
package time_adjust_ctrl_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_ADJUST = 1'b1
   } state_e;

   typedef enum logic [3:0] {
      SEL_MS_LO,   SEL_MS_HI,   SEL_SEC_LO,  SEL_SEC_HI,
      SEL_MIN_LO,  SEL_MIN_HI,  SEL_HOUR_LO, SEL_HOUR_HI,
      SEL_DAY_LO,  SEL_DAY_HI,  SEL_MON_LO,  SEL_MON_HI,
      SEL_YEAR_0,  SEL_YEAR_1,  SEL_YEAR_2,  SEL_YEAR_3
   } field_e;

   localparam int KEY_MODE = 0;
   localparam int KEY_NEXT = 1;
   localparam int KEY_CLR  = 2;
   localparam int KEY_ADD  = 3;

   function automatic logic [3:0] next_field(input logic [3:0] sel,
                                             input logic [3:0] first,
                                             input logic [3:0] last);
      return (sel == last) ? first : sel + 4'd1;
   endfunction

endpackage

// File: rtl/time_adjust_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One raw active-low key: 2-flop synchroniser, debounce filter and a one-cycle
// press strobe on the debounced released->pressed transition.
// Ports:
//   CLOCK_50  in  system clock
//   rst_n     in  asynchronous active-low reset
//   key_n     in  raw key, low = pressed
//   level     out debounced level, 1 = pressed (registered)
//   press     out one-cycle strobe when level becomes pressed (registered)
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic CLOCK_50,
   input  logic rst_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // sync[1] is the metastability-filtered key, already inverted to pressed=1
   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours regardless of block order.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], ~key_n};
      end
   end

   // Counts consecutive samples that disagree with the accepted level; any
   // agreeing sample restarts the count, so bounce never accumulates.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync[1];
            press <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_adjust_ctrl.sv
// -----------------------------------------------------------------------------
// time_adjust_ctrl
// Front-panel controller for the time_float counter chain. Debounces four raw
// keys, runs a RUN/ADJUST FSM and drives time_float's adjust/select/add/clr as
// registered, glitch-free signals, plus a blink mask for the display.
// Optional build macro: AUTO_REPEAT_EN (auto-repeat of a held add key).
// Ports:
//   CLOCK_50    in   system clock, 50 MHz
//   rst_n       in   asynchronous active-low reset
//   key_mode_n  in   raw key, low = pressed: enter/leave ADJUST
//   key_next_n  in   raw key, low = pressed: next field
//   key_add_n   in   raw key, low = pressed: increment field
//   key_clr_n   in   raw key, low = pressed: clear field
//   adjust      out  1 = clock-driven (RUN), 0 = manual
//   select      out  field index 0..15
//   add         out  increment pulse, PULSE_CYCLES wide
//   clr         out  clear pulse, PULSE_CYCLES wide
//   blink_mask  out  one-hot of select gated by blink phase, 0 in RUN
//   in_adjust   out  status LED, 1 in ADJUST
// -----------------------------------------------------------------------------
module time_adjust_ctrl
   import time_adjust_ctrl_pkg::*;
#(
`ifdef AUTO_REPEAT_EN
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
`endif
   parameter int         DEBOUNCE_CYCLES = 1_000_000,
   parameter int         PULSE_CYCLES    = 4,
   parameter logic [3:0] SEL_FIRST       = SEL_SEC_LO,
   parameter logic [3:0] SEL_LAST        = SEL_YEAR_3,
   parameter int         TIMEOUT_CYCLES  = 500_000_000,
   parameter int         BLINK_HALF      = 12_500_000
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        key_mode_n,
   input  logic        key_next_n,
   input  logic        key_add_n,
   input  logic        key_clr_n,
   output logic        adjust,
   output logic [3:0]  select,
   output logic        add,
   output logic        clr,
   output logic [15:0] blink_mask,
   output logic        in_adjust
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   // ---------------------------------------------------------------- keys
   logic [3:0] key_raw, key_level, key_press;

   assign key_raw[KEY_MODE] = key_mode_n;
   assign key_raw[KEY_NEXT] = key_next_n;
   assign key_raw[KEY_CLR]  = key_clr_n;
   assign key_raw[KEY_ADD]  = key_add_n;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .CLOCK_50 (CLOCK_50),
         .rst_n    (rst_n),
         .key_n    (key_raw[k]),
         .level    (key_level[k]),
         .press    (key_press[k])
      );
   end

   // Only the add level feeds logic, and only with auto-repeat built in.
   logic unused_key_level;
   assign unused_key_level = ^key_level;

   // ---------------------------------------------------------------- state
   state_e        state, state_n;
   logic [3:0]    select_n;
   logic          adjust_n, add_n, clr_n, in_adjust_n;
   logic [15:0]   blink_mask_n;
   logic [PW-1:0] pulse_cnt, pulse_cnt_n;
   logic [TW-1:0] timer, timer_n;
   logic [BW-1:0] blink_cnt, blink_cnt_n;
   logic          phase, phase_n;
   logic          pend_mode, pend_next, pend_clr, pend_add;
   logic          pend_mode_n, pend_next_n, pend_clr_n, pend_add_n;

   logic ev_add, ev_any, busy, timeout;
   logic req_mode, req_next, req_clr, req_add;

   // ---------------------------------------------------------- auto-repeat
`ifdef AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rpt_cnt;
   logic          rpt_armed, rpt_hold, rpt_ev;

   // Counting restarts on every genuine press so the first repeat is always
   // REPEAT_DELAY after the press event; afterwards the period applies.
   assign rpt_hold = (state == ST_ADJUST) && key_level[KEY_ADD] && !key_press[KEY_ADD];
   assign rpt_ev   = rpt_hold && (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST));

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (!rpt_hold) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_ev) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

   assign ev_add = key_press[KEY_ADD] | rpt_ev;
`else
   assign ev_add = key_press[KEY_ADD];
`endif

   assign ev_any  = key_press[KEY_MODE] | key_press[KEY_NEXT] | key_press[KEY_CLR] | ev_add;
   // A pulse in flight plus the one guard cycle after it blocks any action.
   assign busy    = (pulse_cnt != '0);
   assign timeout = (timer == TIMER_MAX);

   // Requests merge fresh strobes with the 1-deep pending flags.
   assign req_mode = key_press[KEY_MODE] | pend_mode | timeout;
   assign req_next = key_press[KEY_NEXT] | pend_next;
   assign req_clr  = key_press[KEY_CLR]  | pend_clr;
   assign req_add  = ev_add              | pend_add;

   // ------------------------------------------------------- next-state logic
   // NOTE: every signal written here gets a default first, so no path through
   // the block can leave one unassigned and infer a latch.
   always_comb begin
      state_n     = state;
      select_n    = select;
      adjust_n    = adjust;
      pend_mode_n = 1'b0;
      pend_next_n = 1'b0;
      pend_clr_n  = 1'b0;
      pend_add_n  = 1'b0;

      // Pulse shaping: add/clr drop when the count reaches 0; the extra cycle
      // at count 0 -> not busy gives the guard cycle after the pulse.
      if (busy) begin
         pulse_cnt_n = pulse_cnt - 1'b1;
         add_n       = add && (pulse_cnt_n != '0);
         clr_n       = clr && (pulse_cnt_n != '0);
      end else begin
         pulse_cnt_n = '0;
         add_n       = 1'b0;
         clr_n       = 1'b0;
      end

      // Idle timer saturates at the timeout value until an exit clears it.
      if (state == ST_ADJUST && !ev_any) begin
         timer_n = timeout ? timer : timer + 1'b1;
      end else begin
         timer_n = '0;
      end

      if (blink_cnt == BLINK_LAST) begin
         blink_cnt_n = '0;
         phase_n     = ~phase;
      end else begin
         blink_cnt_n = blink_cnt + 1'b1;
         phase_n     = phase;
      end

      case (state)
         ST_RUN: begin
            if (key_press[KEY_MODE]) begin
               state_n     = ST_ADJUST;
               select_n    = SEL_FIRST;
               adjust_n    = 1'b0;
               timer_n     = '0;
               blink_cnt_n = '0;
               phase_n     = 1'b1;
            end
         end
         ST_ADJUST: begin
            // Anything not acted on this cycle stays (or becomes) pending.
            pend_mode_n = req_mode;
            pend_next_n = req_next;
            pend_clr_n  = req_clr;
            pend_add_n  = req_add;
            if (!busy) begin
               if (req_mode) begin
                  state_n     = ST_RUN;
                  adjust_n    = 1'b1;
                  timer_n     = '0;
                  pend_mode_n = 1'b0;
                  pend_next_n = 1'b0;
                  pend_clr_n  = 1'b0;
                  pend_add_n  = 1'b0;
               end else if (req_next) begin
                  select_n    = next_field(select, SEL_FIRST, SEL_LAST);
                  pend_next_n = 1'b0;
                  blink_cnt_n = '0;
                  phase_n     = 1'b1;
               end else if (req_clr) begin
                  pulse_cnt_n = PULSE_LOAD;
                  clr_n       = 1'b1;
                  pend_clr_n  = 1'b0;
               end else if (req_add) begin
                  pulse_cnt_n = PULSE_LOAD;
                  add_n       = 1'b1;
                  pend_add_n  = 1'b0;
               end
            end
         end
      endcase

      in_adjust_n  = (state_n == ST_ADJUST);
      blink_mask_n = (state_n == ST_ADJUST && phase_n) ? (16'h0001 << select_n) : 16'h0000;
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         select     <= 4'd0;
         adjust     <= 1'b1;
         add        <= 1'b0;
         clr        <= 1'b0;
         blink_mask <= 16'h0000;
         in_adjust  <= 1'b0;
         pulse_cnt  <= '0;
         timer      <= '0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
         pend_mode  <= 1'b0;
         pend_next  <= 1'b0;
         pend_clr   <= 1'b0;
         pend_add   <= 1'b0;
      end else begin
         state      <= state_n;
         select     <= select_n;
         adjust     <= adjust_n;
         add        <= add_n;
         clr        <= clr_n;
         blink_mask <= blink_mask_n;
         in_adjust  <= in_adjust_n;
         pulse_cnt  <= pulse_cnt_n;
         timer      <= timer_n;
         blink_cnt  <= blink_cnt_n;
         phase      <= phase_n;
         pend_mode  <= pend_mode_n;
         pend_next  <= pend_next_n;
         pend_clr   <= pend_clr_n;
         pend_add   <= pend_add_n;
      end
   end

endmodule
